// File: rtl/fft_peak_classifier_if.sv
// rtl/fft_peak_classifier_if.sv - bin input, threshold write and result output channels of fft_peak_classifier
interface fft_peak_classifier_if #(
  parameter int BIT_WIDTH = 32
);
  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] thresh_msg;
  logic                 thresh_val;
  logic                 thresh_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic                 send_val;
  logic                 send_rdy;

  modport master (
    output recv_msg, recv_val, thresh_msg, thresh_val, send_rdy,
    input  recv_rdy, thresh_rdy, send_msg, send_val
  );

  modport slave (
    input  recv_msg, recv_val, thresh_msg, thresh_val, send_rdy,
    output recv_rdy, thresh_rdy, send_msg, send_val
  );
endinterface

// File: rtl/fft_peak_classifier.sv
// rtl/fft_peak_classifier.sv - per-frame peak bin search over bins 1..N/2 with threshold detect
// Optional FFT_PEAK_MAG_WORD_EN adds a second output word carrying the peak magnitude.
module fft_peak_classifier #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_peak_classifier_if.slave  bus
);
  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] CNT_TWO  = IDX_W'(2);
  localparam logic [IDX_W-1:0] CNT_HALF = IDX_W'(N_SAMPLES / 2);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_SAMPLES - 1);

  localparam logic [1:0] ST_RECV   = 2'd0;
  localparam logic [1:0] ST_RESULT = 2'd1;
`ifdef FFT_PEAK_MAG_WORD_EN
  localparam logic [1:0] ST_MAG    = 2'd2;
`endif

  // Fixed-point scaling does not affect magnitude ordering; kept only for interface parity.
  if (DECIMAL_PT >= BIT_WIDTH) begin : g_frac_wider_than_word
  end

  logic [1:0]           state;
  logic [IDX_W-1:0]     cnt;
  logic [BIT_WIDTH-2:0] peak_mag;
  logic [IDX_W-1:0]     peak_idx;
  logic [BIT_WIDTH-1:0] thresh;
  logic [BIT_WIDTH-1:0] neg_msg;
  logic [BIT_WIDTH-2:0] mag;
  logic                 detect;
  logic                 recv_fire;
  logic                 send_fire;
  logic                 thresh_fire;
  logic                 is_candidate;

  assign bus.recv_rdy   = (state == ST_RECV);
  assign bus.thresh_rdy = (state == ST_RECV) && (cnt == '0);
  assign bus.send_val   = (state != ST_RECV);

  assign recv_fire    = bus.recv_val && bus.recv_rdy;
  assign send_fire    = bus.send_val && bus.send_rdy;
  assign thresh_fire  = bus.thresh_val && bus.thresh_rdy;
  assign is_candidate = (cnt >= CNT_TWO) && (cnt <= CNT_HALF);

  // Only the most negative input still has its sign bit set after negation.
  assign neg_msg = ~bus.recv_msg + BIT_WIDTH'(1);

  always_comb begin
    mag = bus.recv_msg[BIT_WIDTH-2:0];
    if (bus.recv_msg[BIT_WIDTH-1]) begin
      if (neg_msg[BIT_WIDTH-1]) begin
        mag = '1;
      end else begin
        mag = neg_msg[BIT_WIDTH-2:0];
      end
    end
  end

  assign detect = ({1'b0, peak_mag} > thresh);

  always_comb begin
    bus.send_msg = '0;
    case (state)
      ST_RESULT: begin
        bus.send_msg[BIT_WIDTH-1] = detect;
        bus.send_msg[IDX_W-1:0]   = peak_idx;
      end
`ifdef FFT_PEAK_MAG_WORD_EN
      ST_MAG: begin
        bus.send_msg = {1'b0, peak_mag};
      end
`endif
      default: begin
        bus.send_msg = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RECV;
      cnt      <= '0;
      peak_mag <= '0;
      peak_idx <= '0;
      thresh   <= '0;
    end else begin
      if (thresh_fire) begin
        thresh <= bus.thresh_msg;
      end
      case (state)
        ST_RECV: begin
          if (recv_fire) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_ONE) begin
              peak_mag <= mag;
              peak_idx <= CNT_ONE;
            end else if (is_candidate && (mag > peak_mag)) begin
              peak_mag <= mag;
              peak_idx <= cnt;
            end
            if (cnt == CNT_LAST) begin
              state <= ST_RESULT;
            end
          end
        end
        ST_RESULT: begin
          if (send_fire) begin
`ifdef FFT_PEAK_MAG_WORD_EN
            state <= ST_MAG;
`else
            state <= ST_RECV;
`endif
          end
        end
`ifdef FFT_PEAK_MAG_WORD_EN
        ST_MAG: begin
          if (send_fire) begin
            state <= ST_RECV;
          end
        end
`endif
        default: begin
          state <= ST_RECV;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_classifier.sv
// tb/tb_fft_peak_classifier.sv - scoreboard bench for fft_peak_classifier (honours FFT_PEAK_MAG_WORD_EN)
module tb_fft_peak_classifier;
  typedef logic [31:0] frame_t [8];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_peak_classifier_if #(.BIT_WIDTH(32)) bus ();

  fft_peak_classifier #(
    .BIT_WIDTH (32),
    .DECIMAL_PT(16),
    .N_SAMPLES (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_thresh = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  task automatic push_expected(input frame_t f);
    logic [31:0] pm;
    logic [31:0] m;
    logic [31:0] pi;
    pm = abs_sat(f[1]);
    pi = 32'd1;
    for (int i = 2; i <= 4; i++) begin
      m = abs_sat(f[i]);
      if (m > pm) begin
        pm = m;
        pi = 32'(i);
      end
    end
    exp_q.push_back(((pm > cur_thresh) ? 32'h8000_0000 : 32'h0) | pi);
    pushed++;
`ifdef FFT_PEAK_MAG_WORD_EN
    exp_q.push_back(pm);
    pushed++;
`endif
  endtask

  always @(negedge clk) begin
    if (reset && bus.send_val && bus.send_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(exp_q.size()), 32'd1);
      end else begin
        check("result", bus.send_msg, exp_q.pop_front());
        popped++;
      end
    end
  end

  task automatic drive_bin(input logic [31:0] v);
    int t;
    t = 0;
    bus.recv_val = 1'b1;
    bus.recv_msg = v;
    while (!bus.recv_rdy && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("recv_rdy_timeout", 32'(bus.recv_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.recv_val   = 1'b0;
    bus.thresh_val = 1'b0;
  endtask

  task automatic drive_frame(input frame_t f, input bit wr_thresh, input logic [31:0] tv);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 && wr_thresh) begin
        bus.thresh_val = 1'b1;
        bus.thresh_msg = tv;
        cur_thresh     = tv;
      end
      drive_bin(f[i]);
    end
    push_expected(f);
  endtask

  task automatic write_thresh(input logic [31:0] v);
    int t;
    t = 0;
    bus.thresh_val = 1'b1;
    bus.thresh_msg = v;
    while (!bus.thresh_rdy && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("thresh_rdy_timeout", 32'(bus.thresh_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.thresh_val = 1'b0;
    cur_thresh     = v;
  endtask

  task automatic drain_and_check_idle(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_recv_rdy"}, 32'(bus.recv_rdy), 32'd1);
    check({tag, "_thresh_rdy"}, 32'(bus.thresh_rdy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_recv_rdy"}, 32'(bus.recv_rdy), 32'd1);
    check({tag, "_thresh_rdy"}, 32'(bus.thresh_rdy), 32'd1);
    check({tag, "_send_val"}, 32'(bus.send_val), 32'd0);
    check({tag, "_send_msg"}, bus.send_msg, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_t      f;
    logic [31:0] held;

    bus.recv_val   = 1'b0;
    bus.recv_msg   = '0;
    bus.thresh_val = 1'b0;
    bus.thresh_msg = '0;
    bus.send_rdy   = 1'b1;
    reset          = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // DC and bin 7 are large but must be ignored.
    f = '{32'd100, 32'd5, 32'd300, 32'(-700), 32'd20, 32'd0, 32'd0, 32'd9999};
    drive_frame(f, 1'b0, 32'd0);
    drain_and_check_idle("frame1");

    write_thresh(32'd700);
    f = '{32'd0, 32'd50, 32'd50, 32'd10, 32'(-700), 32'd0, 32'd0, 32'd0};
    drive_frame(f, 1'b0, 32'd0);
    drain_and_check_idle("frame2");

    f = '{32'd0, 32'h8000_0000, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0};
    drive_frame(f, 1'b0, 32'd0);
    drain_and_check_idle("frame3");

    bus.send_rdy = 1'b0;
    f = '{32'd0, 32'd1, 32'd2, 32'd3000, 32'd4, 32'd0, 32'd0, 32'd0};
    drive_frame(f, 1'b0, 32'd0);
    held = exp_q[0];
    repeat (5) begin
      @(negedge clk);
      check("stall_send_val", 32'(bus.send_val), 32'd1);
      check("stall_send_msg", bus.send_msg, held);
      check("stall_recv_rdy", 32'(bus.recv_rdy), 32'd0);
      check("stall_thresh_rdy", 32'(bus.thresh_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.send_rdy = 1'b1;
    drain_and_check_idle("stall");

    for (int i = 0; i < 4; i++) drive_bin(32'd500 + 32'(i));
    reset = 1'b0;
    cur_thresh = 32'd0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    f = '{32'd0, 32'd9, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    drive_frame(f, 1'b0, 32'd0);
    drain_and_check_idle("fresh");

    drive_frame(f, 1'b1, 32'd10);
    drain_and_check_idle("same_cycle_thresh");

    check("words_delivered", 32'(popped), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_peak_classifier.md
# fft_peak_classifier

Streaming post-processing stage that consumes the serialized FFT output (one fixed-point bin per val/rdy beat, N_SAMPLES beats per frame), finds the strongest bin in the meaningful half-spectrum and emits one classification word per frame. It sits directly downstream of the FFT serializer, in parallel with the output crossbar. It is fed by a serializer output port and drains into an interconnect sink port. Its detection threshold is loaded through a dedicated router address.

## Interface
- BIT_WIDTH, 32: bin and message width (signed two's-complement, fixed point)
- DECIMAL_PT, 16: fractional bits; informational only, no arithmetic depends on it
- N_SAMPLES, 8: bins per frame; power of two, ≥4; IDX_W = $clog2(N_SAMPLES)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- recv_msg  in  BIT_WIDTH  FFT bin value from the serializer
- recv_val  in  1  bin valid
- recv_rdy  out  1  block accepts a bin
- thresh_msg  in  BIT_WIDTH  unsigned magnitude threshold
- thresh_val  in  1  threshold write valid
- thresh_rdy  out  1  threshold write accepted
- send_msg  out  BIT_WIDTH  classification / magnitude word
- send_val  out  1  result valid
- send_rdy  in  1  downstream accepts result

## Operation
- Handshake: a transfer occurs on a rising edge with val && rdy. All outputs are driven from registers or decoded from state only; there is no combinational val-to-rdy path.
- State RECV: recv_rdy=1 and send_val=0. Bin counter cnt (IDX_W bits) counts accepted bins 0..N_SAMPLES-1.
- Magnitude: mag = |recv_msg| as an unsigned BIT_WIDTH-1-bit value. The most negative input, -2^(BIT_WIDTH-1), saturates to 2^(BIT_WIDTH-1)-1.
- Candidate bins are 1..N_SAMPLES/2 inclusive. Bin 0 (DC) and bins above N_SAMPLES/2 are accepted and discarded.
- At cnt==1: load peak_mag=mag and peak_idx=1 unconditionally.
- At cnt 2..N_SAMPLES/2: update peak_mag/peak_idx only if mag > peak_mag (strict). On a tie the lowest index wins.
- On the handshake of cnt==N_SAMPLES-1: cnt wraps to 0 and the state goes to RESULT.
- State RESULT: recv_rdy=0 and send_val=1.
  - send_msg[BIT_WIDTH-1] = detect, where detect = (peak_mag > thresh), an unsigned strict compare.
  - send_msg[IDX_W-1:0] = peak_idx.
  - All other bits are 0.
- On the send handshake in RESULT: go to MAG (macro defined) or RECV (macro undefined).
- Threshold register thresh resets to 0. thresh_rdy=1 only in RECV with cnt==0 (frame boundary). A write in the same cycle as the first bin of a frame is accepted and applies to that frame.
- Reset mid-frame: the partial frame is dropped. cnt, peak_mag, peak_idx and thresh clear, and the state returns to RECV.

## Timing
- Reset values:
  - recv_rdy=1, thresh_rdy=1
  - send_val=0, send_msg=0
  - state RECV, cnt=0, thresh=0
- Latency: send_val rises on the first edge after the last-bin handshake, so the result is visible one cycle later.
- Throughput: N_SAMPLES+1 cycles per frame when send_rdy is held high (N_SAMPLES+2 with the macro).
- Backpressure: send_msg is stable while send_val=1 && send_rdy=0, and recv_rdy stays 0 for the entire stall.
- Back-to-back operation: the cycle after the final send handshake is RECV, with recv_rdy=1 and thresh_rdy=1.
- recv_val while recv_rdy=0 has no effect. The upstream device holds its data.

## Configuration
- FFT_PEAK_MAG_WORD_EN defined:
  - Adds state MAG after RESULT. In MAG, send_val=1 and send_msg = {1'b0, peak_mag}.
  - On the handshake in MAG, the state goes to RECV. Two output words are produced per frame.
- FFT_PEAK_MAG_WORD_EN undefined: the MAG state and its logic are absent, and one word is produced per frame.

## Test plan
All scenarios use BIT_WIDTH=32 and N_SAMPLES=8. Candidate bins are 1..4 and IDX_W=3.
- Reset, then frame [100,5,300,-700,20,0,0,9999] with thresh=0 -> send_msg=0x80000003. Bin 7 is ignored. With the macro, a second word 0x000002BC follows.
- Write thresh=700, then frame [0,50,50,10,-700,0,0,0] -> peak at bin 4, mag 700, not greater than thresh -> send_msg=0x00000004. The tie between bins 1 and 2 does not matter.
- Frame [0,0x80000000,1,2,3,0,0,0] -> saturated mag 0x7FFFFFFF at bin 1 -> send_msg=0x80000001.
- Hold send_rdy=0 for 5 cycles after the last bin -> send_msg is stable, recv_rdy=0 and thresh_rdy=0 throughout, and one result is delivered on release.
- Assert reset after 4 bins, release, then send a full fresh frame [0,9,1,1,1,0,0,0] -> exactly one result, 0x80000001. No stale state from the dropped frame.
- Assert thresh_val together with the first bin of a frame (thresh=10), then frame [0,9,1,1,1,0,0,0] -> send_msg=0x00000001. The new threshold applies to that same frame.
